sample_addr_gen: RTL and testbench

SAMPLE_ADDR_GEN -- requirements
Module: sample_addr_gen

---
 rtl/sag_pkg.sv | 25 ++
 rtl/sag_voice_step.sv | 78 +++++++
 rtl/sample_addr_gen.sv | 167 ++++++++++++++++
 tb/tb_sample_addr_gen.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sag_pkg.sv
// Shared definitions for the sample address generator.
//   - default parameter values for sample_addr_gen / sag_voice_step
//   - register-select codes carried on REG_SEL_IN
//   - sweep FSM state encoding
// Optional feature macro used by the slice: SAG_LOOP_EN (see sag_voice_step).
package sag_pkg;

  localparam int SAG_DEF_NUM_VOICES = 16;
  localparam int SAG_DEF_ADDR_W     = 17;
  localparam int SAG_DEF_FRAC_W     = 10;
  localparam int SAG_DEF_PITCH_W    = 16;

  localparam logic [2:0] SEL_PITCH    = 3'd0;
  localparam logic [2:0] SEL_KEY_ON   = 3'd1;
  localparam logic [2:0] SEL_LOOP     = 3'd2;
  localparam logic [2:0] SEL_END      = 3'd3;
  localparam logic [2:0] SEL_STOP     = 3'd4;
  localparam logic [2:0] SEL_CLR_FLAG = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sag_state_e;

endpackage

// File: rtl/sag_voice_step.sv
// Combinational phase advance for one voice; a single instance is
// time-shared by the sweep, one voice per cycle.
//
// Macro: SAG_LOOP_EN -- when defined, a voice whose loop address is below
// its end address wraps back into the loop instead of stopping. When
// undefined every voice is one-shot (the loop input is still evaluated but
// never selected).
//
// Ports
//   phase       in   current phase, integer.fraction
//   pitch       in   unsigned phase increment (zero-extended)
//   loop_addr   in   loop start, integer address
//   end_addr    in   end address, integer address
//   active      in   voice is sounding
//   next_phase  out  phase to store after this slot
//   next_active out  active bit to store after this slot
//   end_hit     out  one-shot voice reached its end this slot
module sag_voice_step
  import sag_pkg::*;
#(
  parameter int ADDR_W  = SAG_DEF_ADDR_W,
  parameter int FRAC_W  = SAG_DEF_FRAC_W,
  parameter int PITCH_W = SAG_DEF_PITCH_W
) (
  input  logic [ADDR_W+FRAC_W-1:0] phase,
  input  logic [PITCH_W-1:0]       pitch,
  input  logic [ADDR_W-1:0]        loop_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  input  logic                     active,
  output logic [ADDR_W+FRAC_W-1:0] next_phase,
  output logic                     next_active,
  output logic                     end_hit
);

  localparam int PH_W  = ADDR_W + FRAC_W;
  localparam int SUM_W = PH_W + 1;

`ifdef SAG_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] span;
  logic [SUM_W-1:0] wrapped;
  logic             reached;
  logic             still_over;
  logic             use_loop;

  // One extra bit so a carry out of the integer field is seen as "past end".
  assign sum     = {1'b0, phase} + {{(SUM_W-PITCH_W){1'b0}}, pitch};
  assign reached = sum[PH_W] || (sum[PH_W-1:FRAC_W] >= end_addr);

  assign span       = {1'b0, end_addr - loop_addr, {FRAC_W{1'b0}}};
  assign wrapped    = sum - span;
  // A pitch larger than the loop length can overshoot even after one wrap.
  assign still_over = wrapped[PH_W] || (wrapped[PH_W-1:FRAC_W] >= end_addr);
  assign use_loop   = LOOP_EN && (loop_addr < end_addr);

  always_comb begin
    next_phase  = phase;
    next_active = active;
    end_hit     = 1'b0;
    if (active) begin
      if (!reached) begin
        next_phase = sum[PH_W-1:0];
      end else if (use_loop) begin
        next_phase = still_over ? {loop_addr, {FRAC_W{1'b0}}} : wrapped[PH_W-1:0];
      end else begin
        next_phase  = {end_addr, {FRAC_W{1'b0}}};
        next_active = 1'b0;
        end_hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_addr_gen.sv
// Wavetable sample address generator. Each SYNC_IN starts one sweep that
// presents every voice once, in order, and advances its phase by its pitch.
//
// Macro: SAG_LOOP_EN -- enables looping voices (handled in sag_voice_step).
//
// Ports
//   XTAL_IN        in   clock, rising edge
//   RESET_IN       in   synchronous active-high reset
//   SYNC_IN        in   frame strobe, starts a sweep from IDLE
//   REG_WE_IN      in   register write strobe
//   REG_VOICE_IN   in   target voice of the write
//   REG_SEL_IN     in   register select (see sag_pkg SEL_*)
//   REG_DATA_IN    in   write data (pitch uses the low PITCH_W bits)
//   WR_A_OUT       out  integer part of the presented (pre-increment) phase
//   FRAC_OUT       out  fractional part of the presented phase
//   SLOT_OUT       out  voice index of the presented slot
//   VALID_OUT      out  a slot is presented this cycle
//   ACTIVE_OUT     out  presented voice is sounding
//   END_FLAGS_OUT  out  sticky per-voice end-reached flags
//   IRQ_OUT        out  OR of END_FLAGS_OUT
//   OVERRUN_OUT    out  one-cycle pulse, SYNC_IN seen during a sweep
//
// state    | meaning
// ST_IDLE  | waiting for SYNC_IN; outputs hold last presented slot
// ST_SWEEP | presenting voice `slot`, advancing it at the end of the cycle
module sample_addr_gen
  import sag_pkg::*;
#(
  parameter int NUM_VOICES = SAG_DEF_NUM_VOICES,
  parameter int ADDR_W     = SAG_DEF_ADDR_W,
  parameter int FRAC_W     = SAG_DEF_FRAC_W,
  parameter int PITCH_W    = SAG_DEF_PITCH_W
) (
  input  logic                          XTAL_IN,
  input  logic                          RESET_IN,
  input  logic                          SYNC_IN,
  input  logic                          REG_WE_IN,
  input  logic [$clog2(NUM_VOICES)-1:0] REG_VOICE_IN,
  input  logic [2:0]                    REG_SEL_IN,
  input  logic [ADDR_W-1:0]             REG_DATA_IN,
  output logic [ADDR_W-1:0]             WR_A_OUT,
  output logic [FRAC_W-1:0]             FRAC_OUT,
  output logic [$clog2(NUM_VOICES)-1:0] SLOT_OUT,
  output logic                          VALID_OUT,
  output logic                          ACTIVE_OUT,
  output logic [NUM_VOICES-1:0]         END_FLAGS_OUT,
  output logic                          IRQ_OUT,
  output logic                          OVERRUN_OUT
);

  localparam int VW   = $clog2(NUM_VOICES);
  localparam int PH_W = ADDR_W + FRAC_W;
  localparam logic [VW-1:0] LAST_SLOT = VW'(NUM_VOICES - 1);

  sag_state_e          state;
  logic [VW-1:0]       slot;
  logic                in_sweep;

  // Per-voice state. The start address is loaded straight into phase on
  // key-on; nothing reads it afterwards, so it is not kept separately.
  logic [PH_W-1:0]     phase     [NUM_VOICES];
  logic [PITCH_W-1:0]  pitch     [NUM_VOICES];
  logic [ADDR_W-1:0]   loop_addr [NUM_VOICES];
  logic [ADDR_W-1:0]   end_addr  [NUM_VOICES];
  logic [NUM_VOICES-1:0] active;
  logic [NUM_VOICES-1:0] end_flags;

  logic [ADDR_W-1:0]   hold_addr;
  logic [FRAC_W-1:0]   hold_frac;
  logic                overrun;

  logic [PH_W-1:0]     cur_phase;
  logic [PH_W-1:0]     step_phase;
  logic                step_active;
  logic                step_end_hit;

  assign in_sweep  = (state == ST_SWEEP);
  assign cur_phase = phase[slot];

  sag_voice_step #(
    .ADDR_W  (ADDR_W),
    .FRAC_W  (FRAC_W),
    .PITCH_W (PITCH_W)
  ) u_step (
    .phase       (cur_phase),
    .pitch       (pitch[slot]),
    .loop_addr   (loop_addr[slot]),
    .end_addr    (end_addr[slot]),
    .active      (active[slot]),
    .next_phase  (step_phase),
    .next_active (step_active),
    .end_hit     (step_end_hit)
  );

  // Outside a sweep the address outputs show the last presented slot.
  assign WR_A_OUT      = in_sweep ? cur_phase[PH_W-1:FRAC_W] : hold_addr;
  assign FRAC_OUT      = in_sweep ? cur_phase[FRAC_W-1:0]    : hold_frac;
  assign SLOT_OUT      = slot;
  assign VALID_OUT     = in_sweep;
  assign ACTIVE_OUT    = in_sweep && active[slot];
  assign END_FLAGS_OUT = end_flags;
  assign IRQ_OUT       = |end_flags;
  assign OVERRUN_OUT   = overrun;

  always_ff @(posedge XTAL_IN) begin
    if (RESET_IN) begin
      state     <= ST_IDLE;
      slot      <= '0;
      active    <= '0;
      end_flags <= '0;
      hold_addr <= '0;
      hold_frac <= '0;
      overrun   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v]     <= '0;
        pitch[v]     <= '0;
        loop_addr[v] <= '0;
        end_addr[v]  <= '0;
      end
    end else begin
      overrun <= in_sweep && SYNC_IN;

      case (state)
        ST_IDLE: begin
          if (SYNC_IN) begin
            state <= ST_SWEEP;
            slot  <= '0;
          end
        end
        ST_SWEEP: begin
          hold_addr     <= cur_phase[PH_W-1:FRAC_W];
          hold_frac     <= cur_phase[FRAC_W-1:0];
          phase[slot]   <= step_phase;
          active[slot]  <= step_active;
          if (step_end_hit) begin
            end_flags[slot] <= 1'b1;
          end
          if (slot == LAST_SLOT) begin
            state <= ST_IDLE;
          end else begin
            slot <= slot + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Placed after the sweep update so a write to the voice being swept
      // overrides its phase/active/flag result for this cycle.
      if (REG_WE_IN) begin
        case (REG_SEL_IN)
          SEL_PITCH: pitch[REG_VOICE_IN] <= REG_DATA_IN[PITCH_W-1:0];
          SEL_KEY_ON: begin
            phase[REG_VOICE_IN]     <= {REG_DATA_IN, {FRAC_W{1'b0}}};
            active[REG_VOICE_IN]    <= 1'b1;
            end_flags[REG_VOICE_IN] <= 1'b0;
          end
          SEL_LOOP:     loop_addr[REG_VOICE_IN] <= REG_DATA_IN;
          SEL_END:      end_addr[REG_VOICE_IN]  <= REG_DATA_IN;
          SEL_STOP:     active[REG_VOICE_IN]    <= 1'b0;
          SEL_CLR_FLAG: end_flags[REG_VOICE_IN] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_addr_gen.sv
module tb_sample_addr_gen;

  localparam int NV = 4;
  localparam int AW = 17;
  localparam int FW = 10;
  localparam int PW = 16;

`ifdef SAG_LOOP_EN
  localparam bit LOOP_ON = 1'b1;
`else
  localparam bit LOOP_ON = 1'b0;
`endif

  logic          XTAL_IN;
  logic          RESET_IN;
  logic          SYNC_IN;
  logic          REG_WE_IN;
  logic [1:0]    REG_VOICE_IN;
  logic [2:0]    REG_SEL_IN;
  logic [AW-1:0] REG_DATA_IN;
  logic [AW-1:0] WR_A_OUT;
  logic [FW-1:0] FRAC_OUT;
  logic [1:0]    SLOT_OUT;
  logic          VALID_OUT;
  logic          ACTIVE_OUT;
  logic [NV-1:0] END_FLAGS_OUT;
  logic          IRQ_OUT;
  logic          OVERRUN_OUT;

  sample_addr_gen #(
    .NUM_VOICES (NV),
    .ADDR_W     (AW),
    .FRAC_W     (FW),
    .PITCH_W    (PW)
  ) dut (
    .XTAL_IN       (XTAL_IN),
    .RESET_IN      (RESET_IN),
    .SYNC_IN       (SYNC_IN),
    .REG_WE_IN     (REG_WE_IN),
    .REG_VOICE_IN  (REG_VOICE_IN),
    .REG_SEL_IN    (REG_SEL_IN),
    .REG_DATA_IN   (REG_DATA_IN),
    .WR_A_OUT      (WR_A_OUT),
    .FRAC_OUT      (FRAC_OUT),
    .SLOT_OUT      (SLOT_OUT),
    .VALID_OUT     (VALID_OUT),
    .ACTIVE_OUT    (ACTIVE_OUT),
    .END_FLAGS_OUT (END_FLAGS_OUT),
    .IRQ_OUT       (IRQ_OUT),
    .OVERRUN_OUT   (OVERRUN_OUT)
  );

  initial XTAL_IN = 1'b0;
  always #5 XTAL_IN = ~XTAL_IN;

  int n_chk  = 0;
  int n_pass = 0;
  int valid_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // Reference model of the voice state.
  logic [AW+FW-1:0] m_phase  [NV];
  logic [PW-1:0]    m_pitch  [NV];
  logic [AW-1:0]    m_loop   [NV];
  logic [AW-1:0]    m_end    [NV];
  logic             m_active [NV];
  logic [NV-1:0]    m_flags;

  typedef struct packed {
    logic [1:0]    slot;
    logic [AW-1:0] addr;
    logic [FW-1:0] frac;
    logic          act;
  } exp_t;
  exp_t sb_q[$];

  function automatic void m_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0; m_pitch[v] = '0; m_loop[v] = '0; m_end[v] = '0; m_active[v] = 1'b0;
    end
    m_flags = '0;
  endfunction

  function automatic void m_step(int v);
    longint sum, endp, w;
    if (!m_active[v]) return;
    sum  = longint'(m_phase[v]) + longint'(m_pitch[v]);
    endp = longint'(m_end[v]) * (longint'(1) << FW);
    if (sum >= endp || sum >= (longint'(1) << (AW + FW))) begin
      if (LOOP_ON && m_loop[v] < m_end[v]) begin
        w = sum - (longint'(m_end[v]) - longint'(m_loop[v])) * (longint'(1) << FW);
        if (w >= endp) w = longint'(m_loop[v]) * (longint'(1) << FW);
        m_phase[v] = w[AW+FW-1:0];
      end else begin
        m_phase[v]  = endp[AW+FW-1:0];
        m_active[v] = 1'b0;
        m_flags[v]  = 1'b1;
      end
    end else begin
      m_phase[v] = sum[AW+FW-1:0];
    end
  endfunction

  function automatic void m_write(int v, logic [2:0] sel, logic [AW-1:0] d);
    case (sel)
      3'd0: m_pitch[v] = d[PW-1:0];
      3'd1: begin m_phase[v] = {d, {FW{1'b0}}}; m_active[v] = 1'b1; m_flags[v] = 1'b0; end
      3'd2: m_loop[v] = d;
      3'd3: m_end[v] = d;
      3'd4: m_active[v] = 1'b0;
      3'd5: m_flags[v] = 1'b0;
      default: ;
    endcase
  endfunction

  // Push the expected presentation of slots 0..n-1, advancing the model.
  function automatic void m_push(int n, bit wr, int wr_slot, logic [2:0] wsel, int wv, logic [AW-1:0] wd);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      e.slot = 2'(s);
      e.addr = m_phase[s][AW+FW-1:FW];
      e.frac = m_phase[s][FW-1:0];
      e.act  = m_active[s];
      sb_q.push_back(e);
      m_step(s);
      if (wr && s == wr_slot) m_write(wv, wsel, wd);
    end
  endfunction

  // Scoreboard consumer.
  always @(negedge XTAL_IN) begin
    if (VALID_OUT) begin
      exp_t e;
      valid_cnt++;
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("slot",   32'(SLOT_OUT),   32'(e.slot));
        chk("addr",   32'(WR_A_OUT),   32'(e.addr));
        chk("frac",   32'(FRAC_OUT),   32'(e.frac));
        chk("active", 32'(ACTIVE_OUT), 32'(e.act));
      end
    end
  end

  task automatic reg_wr(input int v, input logic [2:0] sel, input logic [AW-1:0] d);
    REG_WE_IN    = 1'b1;
    REG_VOICE_IN = 2'(v);
    REG_SEL_IN   = sel;
    REG_DATA_IN  = d;
    @(posedge XTAL_IN); #1;
    REG_WE_IN = 1'b0;
    m_write(v, sel, d);
  endtask

  task automatic run_sweep(input bit wr, input int wr_slot, input logic [2:0] wsel,
                           input int wv, input logic [AW-1:0] wd,
                           input bit ovr, input int ovr_slot);
    int vstart;
    m_push(NV, wr, wr_slot, wsel, wv, wd);
    vstart  = valid_cnt;
    SYNC_IN = 1'b1;
    @(posedge XTAL_IN); #1;
    SYNC_IN = 1'b0;
    for (int s = 0; s < NV; s++) begin
      if (wr && s == wr_slot) begin
        REG_WE_IN = 1'b1; REG_VOICE_IN = 2'(wv); REG_SEL_IN = wsel; REG_DATA_IN = wd;
      end
      if (ovr && s == ovr_slot) SYNC_IN = 1'b1;
      @(negedge XTAL_IN);
      chk("overrun", 32'(OVERRUN_OUT), 32'(ovr && s == ovr_slot + 1));
      @(posedge XTAL_IN); #1;
      REG_WE_IN = 1'b0;
      SYNC_IN   = 1'b0;
    end
    @(negedge XTAL_IN);
    chk("overrun_tail", 32'(OVERRUN_OUT), 32'(ovr && ovr_slot == NV - 1));
    chk("valid_after",  32'(VALID_OUT), 32'd0);
    chk("active_after", 32'(ACTIVE_OUT), 32'd0);
    @(posedge XTAL_IN); #1;
    chk("valid_count", 32'(valid_cnt - vstart), 32'(NV));
    chk("sb_drained",  32'(sb_q.size()), 32'd0);
  endtask

  task automatic sweep();
    run_sweep(1'b0, 0, 3'd0, 0, '0, 1'b0, 0);
  endtask

  task automatic chk_flags(input string tag);
    @(negedge XTAL_IN);
    chk(tag, 32'(END_FLAGS_OUT), 32'(m_flags));
    chk("irq", 32'(IRQ_OUT), 32'(|m_flags));
    @(posedge XTAL_IN); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int vc;
    RESET_IN = 1'b1; SYNC_IN = 1'b0; REG_WE_IN = 1'b0;
    REG_VOICE_IN = '0; REG_SEL_IN = '0; REG_DATA_IN = '0;
    m_reset();
    repeat (3) @(posedge XTAL_IN);
    #1 RESET_IN = 1'b0;

    // Reset state.
    @(negedge XTAL_IN);
    chk("rst_valid", 32'(VALID_OUT), 32'd0);
    chk("rst_active", 32'(ACTIVE_OUT), 32'd0);
    chk("rst_addr", 32'(WR_A_OUT), 32'd0);
    chk("rst_frac", 32'(FRAC_OUT), 32'd0);
    chk("rst_flags", 32'(END_FLAGS_OUT), 32'd0);
    chk("rst_irq", 32'(IRQ_OUT), 32'd0);
    chk("rst_overrun", 32'(OVERRUN_OUT), 32'd0);
    @(posedge XTAL_IN); #1;

    // Idle voices presented with zero address.
    sweep();
    chk_flags("flags_idle");

    // One-shot voice 1.
    reg_wr(1, 3'd0, 17'h00400);
    reg_wr(1, 3'd3, 17'h00104);
    reg_wr(1, 3'd1, 17'h00100);
    repeat (4) sweep();
    @(negedge XTAL_IN);
    chk("v1_flags", 32'(END_FLAGS_OUT), 32'h2);
    chk("v1_irq", 32'(IRQ_OUT), 32'd1);
    @(posedge XTAL_IN); #1;
    sweep();
    chk_flags("v1_flags_hold");

    // Clear the end flag.
    reg_wr(1, 3'd5, '0);
    chk_flags("v1_flag_clr");

    // Voice 0 looping (one-shot when looping is compiled out).
    reg_wr(0, 3'd0, 17'h00600);
    reg_wr(0, 3'd2, 17'h00002);
    reg_wr(0, 3'd3, 17'h00004);
    reg_wr(0, 3'd1, 17'h00000);
    repeat (5) sweep();
    chk_flags("v0_loop_flags");

    // Stop clears active without flagging.
    reg_wr(3, 3'd0, 17'h00100);
    reg_wr(3, 3'd3, 17'h1ffff);
    reg_wr(3, 3'd1, 17'h00010);
    sweep();
    reg_wr(3, 3'd4, '0);
    sweep();
    chk_flags("stop_flags");

    // SYNC_IN during a sweep.
    run_sweep(1'b0, 0, 3'd0, 0, '0, 1'b1, 1);

    // Key-on to voice 2 in its own slot, then pitch write to voice 3 in its slot.
    reg_wr(2, 3'd0, 17'h00080);
    reg_wr(2, 3'd3, 17'h1ffff);
    reg_wr(2, 3'd1, 17'h00020);
    reg_wr(3, 3'd1, 17'h00040);
    run_sweep(1'b1, 2, 3'd1, 2, 17'h00055, 1'b0, 0);
    run_sweep(1'b1, 3, 3'd0, 3, 17'h00300, 1'b0, 0);
    sweep();

    // Reset in the middle of a sweep.
    m_push(2, 1'b0, 0, 3'd0, 0, '0);
    SYNC_IN = 1'b1;
    @(posedge XTAL_IN); #1;
    SYNC_IN = 1'b0;
    @(posedge XTAL_IN); #1;
    RESET_IN = 1'b1;
    @(posedge XTAL_IN); #1;
    RESET_IN = 1'b0;
    m_reset();
    @(negedge XTAL_IN);
    vc = valid_cnt;
    chk("mid_rst_valid", 32'(VALID_OUT), 32'd0);
    chk("mid_rst_addr", 32'(WR_A_OUT), 32'd0);
    chk("mid_rst_frac", 32'(FRAC_OUT), 32'd0);
    chk("mid_rst_slot", 32'(SLOT_OUT), 32'd0);
    chk("mid_rst_flags", 32'(END_FLAGS_OUT), 32'd0);
    chk("mid_rst_sb", 32'(sb_q.size()), 32'd0);
    repeat (4) @(posedge XTAL_IN);
    #1;
    chk("mid_rst_no_valid", 32'(valid_cnt - vc), 32'd0);

    // Voices zeroed after reset.
    sweep();
    chk_flags("post_rst_flags");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
